// File: rtl/div_pkg.sv
// Shared types and sign helpers for the iterative divider.
// Helpers work on a wide word; callers zero-extend in and truncate out.
package div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   localparam int MAX_W = 128;

   function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] v, input logic msb,
                                                  input logic sgn);
      return cond_neg(v, sgn & msb);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
   parameter int D = 32
) (
   input  logic [D:0]   rem_i,
   input  logic         bit_i,
   input  logic [D-1:0] dvs_i,
   output logic [D:0]   rem_o,
   output logic         q_o
);

   logic [D:0]   shifted;
   logic [D+1:0] diff;

   // rem_i[D] is zero while rem_i < divisor; if set, the shifted value always exceeds it.
   assign shifted = {rem_i[D-1:0], bit_i};
   assign diff    = {1'b0, shifted} - {2'b00, dvs_i};
   assign q_o     = rem_i[D] | ~diff[D+1];
   assign rem_o   = q_o ? diff[D:0] : shifted;

endmodule

// File: rtl/div_iter.sv
// Handshaked iterative restoring divider, signed or unsigned per operation,
// resolving BITS_PER_CYCLE quotient bits per CALC cycle.
module div_iter
   import div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = 64,
   parameter int DIVISOR_WIDTH  = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic                      is_signed_i,
   input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
   input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [DIVIDEND_WIDTH-1:0] quotient_o,
   output logic [DIVISOR_WIDTH-1:0]  remainder_o,
   output logic                      div_by_zero_o,
   output logic                      overflow_o,
   output state_t                    dbg_state_o
);

   localparam int W  = DIVIDEND_WIDTH;
   localparam int D  = DIVISOR_WIDTH;
   localparam int B  = BITS_PER_CYCLE;
   localparam int N  = W / B;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   state_t        state_q;
   logic          sd_q, sv_q;
   logic [W-1:0]  dvd_q;
   logic [D:0]    rem_q;
   logic [D-1:0]  dvs_q;
   logic [CW-1:0] cnt_q;
   logic          in_ready_q, out_valid_q, dbz_q, ovf_q;
   logic [W-1:0]  quotient_q;
   logic [D-1:0]  remainder_q;

   logic [W-1:0]     dvd_mag, dvd_d;
   logic [D-1:0]     dvs_mag;
   logic             dvs_zero, ovf_case;
   logic [B:0][D:0]  rem_c;
   logic [B-1:0]     qbits;

   assign dvd_mag  = W'(magnitude(MAX_W'(dividend_i), dividend_i[W-1], is_signed_i));
   assign dvs_mag  = D'(magnitude(MAX_W'(divisor_i), divisor_i[D-1], is_signed_i));
   assign dvs_zero = (divisor_i == '0);
   assign ovf_case = is_signed_i && (dividend_i == MIN_NEG) && (divisor_i == '1);

   // dvd_q doubles as the quotient: dividend bits leave at the top, quotient bits enter at the bottom.
   assign rem_c[0] = rem_q;
   for (genvar k = 0; k < B; k++) begin : g_step
      div_step #(.D(D)) u_step (
         .rem_i (rem_c[k]),
         .bit_i (dvd_q[W-1-k]),
         .dvs_i (dvs_q),
         .rem_o (rem_c[k+1]),
         .q_o   (qbits[B-1-k])
      );
   end
   assign dvd_d = (dvd_q << B) | W'(qbits);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         sd_q        <= 1'b0;
         sv_q        <= 1'b0;
         dvd_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid_i) begin
               sd_q       <= is_signed_i & dividend_i[W-1];
               sv_q       <= is_signed_i & divisor_i[D-1];
               dvd_q      <= dvd_mag;
               dvs_q      <= dvs_mag;
               rem_q      <= '0;
               in_ready_q <= 1'b0;
               if (dvs_zero) begin
                  quotient_q  <= '1;
                  remainder_q <= dividend_i[D-1:0];
                  dbz_q       <= 1'b1;
                  ovf_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else if (ovf_case) begin
                  quotient_q  <= dividend_i;
                  remainder_q <= '0;
                  dbz_q       <= 1'b0;
                  ovf_q       <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q   <= CW'(N - 1);
                  state_q <= CALC;
               end
            end
            CALC: begin
               rem_q <= rem_c[B];
               dvd_q <= dvd_d;
               if (cnt_q == '0) state_q <= FIXUP;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            FIXUP: begin
               // Truncating division: remainder takes the dividend's sign.
               quotient_q  <= W'(cond_neg(MAX_W'(dvd_q), sd_q ^ sv_q));
               remainder_q <= D'(cond_neg(MAX_W'(rem_q[D-1:0]), sd_q));
               dbz_q       <= 1'b0;
               ovf_q       <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: if (out_ready_i) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready_o    = in_ready_q;
   assign out_valid_o   = out_valid_q;
   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign div_by_zero_o = dbz_q;
   assign overflow_o    = ovf_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: arithmetic model + scoreboard on the 1-bit/cycle instance,
// plus a 2-bit/cycle instance checked for latency and result.
module tb_div_iter;
   import div_pkg::*;

   // in_valid/in_ready and out_valid/out_ready: a transfer happens on a rising edge where both are 1.
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid1, in_valid2, is_signed, out_ready;
   logic [63:0] dividend;
   logic [31:0] divisor;

   logic        in_ready1, out_valid1, dbz1, ovf1;
   logic [63:0] q1;
   logic [31:0] r1;
   state_t      dbg1;
   logic        in_ready2, out_valid2, dbz2, ovf2;
   logic [63:0] q2;
   logic [31:0] r2;
   state_t      dbg2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;

   // entry: {latency[7:0], quotient[63:0], remainder[31:0], div_by_zero, overflow}
   logic [105:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_iter #(.DIVIDEND_WIDTH(64), .DIVISOR_WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
      .is_signed_i(is_signed), .dividend_i(dividend), .divisor_i(divisor),
      .out_valid_o(out_valid1), .out_ready_i(out_ready), .quotient_o(q1), .remainder_o(r1),
      .div_by_zero_o(dbz1), .overflow_o(ovf1), .dbg_state_o(dbg1));

   div_iter #(.DIVIDEND_WIDTH(64), .DIVISOR_WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
      .is_signed_i(is_signed), .dividend_i(dividend), .divisor_i(divisor),
      .out_valid_o(out_valid2), .out_ready_i(out_ready), .quotient_o(q2), .remainder_o(r2),
      .div_by_zero_o(dbz2), .overflow_o(ovf2), .dbg_state_o(dbg2));

   // ---------------- model ----------------
   // Latency counts rising edges after the acceptance edge until out_valid is seen;
   // special cases answer straight from the acceptance edge.
   function automatic logic [105:0] model(input logic sg, input logic [63:0] a,
                                          input logic [31:0] b, input int norm_lat);
      logic [63:0] q;
      logic [31:0] r;
      logic        dz, ov;
      int          lat;
      longint      sa, sb, qq, rr;
      dz = 1'b0; ov = 1'b0; lat = norm_lat;
      if (b == 32'd0) begin
         q = '1; r = a[31:0]; dz = 1'b1; lat = 0;
      end else if (sg && a == 64'h8000_0000_0000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = '0; ov = 1'b1; lat = 0;
      end else if (sg) begin
         sa = signed'(a);
         sb = longint'(signed'(b));
         qq = sa / sb;
         rr = sa % sb;
         q  = 64'(qq);
         r  = rr[31:0];
      end else begin
         q = a / {32'd0, b};
         r = 32'(a % {32'd0, b});
      end
      return {8'(lat), q, r, dz, ov};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   task automatic timeout(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired (t=%0t)", nm, $time);
   endtask

   // ---------------- driver tasks (called just after a rising edge) ----------------
   task automatic send1(input logic sg, input logic [63:0] a, input logic [31:0] b);
      exp_q.push_back(model(sg, a, b, 65));
      in_valid1 = 1'b1; is_signed = sg; dividend = a; divisor = b;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (in_ready1) break;
      end
      if (!in_ready1) timeout("accept1");
      @(posedge clk); #1;
      acc_cyc   = cyc;
      in_valid1 = 1'b0;
      is_signed = 1'($urandom_range(0, 1));
      dividend  = {$urandom, $urandom};
      divisor   = $urandom;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) timeout("drain1");
      @(posedge clk); #1;
   endtask

   task automatic run2(input logic sg, input logic [63:0] a, input logic [31:0] b);
      logic [105:0] e;
      int           a2;
      e = model(sg, a, b, 33);
      in_valid2 = 1'b1; is_signed = sg; dividend = a; divisor = b;
      @(negedge clk);
      check("in_ready2_idle", 128'(in_ready2), 128'(1));
      @(posedge clk); #1;
      a2 = cyc;
      in_valid2 = 1'b0;
      dividend  = {$urandom, $urandom};
      divisor   = $urandom;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (out_valid2) break;
      end
      if (!out_valid2) timeout("result2");
      else begin
         check("latency2", 128'(cyc - a2), 128'(e[105:98]));
         check("quotient2", 128'(q2), 128'(e[97:34]));
         check("remainder2", 128'(r2), 128'(e[33:2]));
         check("div_by_zero2", 128'(dbz2), 128'(e[1]));
         check("overflow2", 128'(ovf2), 128'(e[0]));
      end
      @(posedge clk); #1;
   endtask

   // ---------------- scoreboard compare (dut1) ----------------
   logic         prev_v1 = 1'b0;
   logic [105:0] cur;
   always @(negedge clk) begin
      if (!reset && out_valid1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
         end else begin
            cur = exp_q[0];
            if (!prev_v1) check("latency", 128'(cyc - acc_cyc), 128'(cur[105:98]));
            check("quotient", 128'(q1), 128'(cur[97:34]));
            check("remainder", 128'(r1), 128'(cur[33:2]));
            check("div_by_zero", 128'(dbz1), 128'(cur[1]));
            check("overflow", 128'(ovf1), 128'(cur[0]));
            check("in_ready_busy", 128'(in_ready1), 128'(0));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
      prev_v1 = out_valid1;
   end

   // ---------------- directed vectors ----------------
   localparam int NV = 12;
   logic        v_sg [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b0};
   logic [63:0] v_a  [NV] = '{64'd100, -64'sd100, -64'sd7, 64'd7,
                              64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
                              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                              64'd0, 64'd5, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
   logic [31:0] v_b  [NV] = '{32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd5, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF};

   logic [105:0] m;

   initial begin
      reset = 1'b1; in_valid1 = 1'b0; in_valid2 = 1'b0; is_signed = 1'b0;
      dividend = '0; divisor = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_in_ready", 128'(in_ready1), 128'(1));
      check("rst_out_valid", 128'(out_valid1), 128'(0));
      check("rst_quotient", 128'(q1), 128'(0));
      check("rst_remainder", 128'(r1), 128'(0));
      check("rst_flags", 128'({dbz1, ovf1}), 128'(0));
      check("rst_state", 128'(dbg1), 128'(IDLE));
      check("rst_in_ready2", 128'(in_ready2), 128'(1));
      check("rst_out_valid2", 128'(out_valid2), 128'(0));

      // hand-computed pins on the model
      m = model(0, 64'd100, 32'd7, 65);
      check("pin_u100_7", 128'(m), 128'({8'd65, 64'd14, 32'd2, 2'b00}));
      m = model(1, -64'sd100, 32'd7, 65);
      check("pin_sm100_7", 128'(m), 128'({8'd65, 64'hFFFF_FFFF_FFFF_FFF2, 32'hFFFF_FFFE, 2'b00}));
      m = model(1, -64'sd7, 32'hFFFF_FFFE, 65);
      check("pin_sm7_m2", 128'(m), 128'({8'd65, 64'd3, 32'hFFFF_FFFF, 2'b00}));
      m = model(1, 64'd7, 32'hFFFF_FFFE, 65);
      check("pin_s7_m2", 128'(m), 128'({8'd65, 64'hFFFF_FFFF_FFFF_FFFD, 32'd1, 2'b00}));
      m = model(1, 64'h1234_5678_9ABC_DEF0, 32'd0, 65);
      check("pin_dbz", 128'(m), 128'({8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h9ABC_DEF0, 2'b10}));
      m = model(1, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 65);
      check("pin_ovf", 128'(m), 128'({8'd0, 64'h8000_0000_0000_0000, 32'd0, 2'b01}));
      m = model(0, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 65);
      check("pin_u_ovf_ops", 128'(m), 128'({8'd65, 64'h8000_0000, 32'h8000_0000, 2'b00}));

      @(posedge clk); #1;
      for (int i = 0; i < NV; i++) begin
         send1(v_sg[i], v_a[i], v_b[i]);
         wait_idle();
      end

      // backpressure then back-to-back acceptance
      begin
         int rel;
         out_ready = 1'b0;
         send1(1'b1, -64'sd100, 32'd7);
         for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid1) break;
         end
         if (!out_valid1) timeout("bp_result");
         repeat (10) @(negedge clk);
         @(posedge clk); #1;
         rel = cyc;
         out_ready = 1'b1;
         send1(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 32'h0001_0001);
         check("back_to_back_accept", 128'(acc_cyc - rel), 128'(2));
         wait_idle();
      end

      // reset in the middle of CALC abandons the operation
      send1(1'b0, 64'hFFFF_0000_1234_5678, 32'h1357);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("mid_calc_state", 128'(dbg1), 128'(CALC));
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_in_ready", 128'(in_ready1), 128'(1));
      check("abort_out_valid", 128'(out_valid1), 128'(0));
      check("abort_quotient", 128'(q1), 128'(0));
      check("abort_remainder", 128'(r1), 128'(0));
      check("abort_flags", 128'({dbz1, ovf1}), 128'(0));
      repeat (80) @(negedge clk);
      @(posedge clk); #1;
      send1(0, 64'd100, 32'd7);
      wait_idle();

      // two bits per cycle
      run2(0, 64'd100, 32'd7);
      run2(1, -64'sd7, 32'hFFFF_FFFE);
      run2(0, 64'h1234_5678_9ABC_DEF0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
